// File: rtl/wb_dma_hs_pkg.sv
// Shared types and constants for the DMA handshake checker.
// Error-type bit positions match err_type_o; the window counters are 8 bits wide.
package wb_dma_hs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CYC,
        BUSY,
        ACKED
    } hs_state_t;

    localparam int unsigned ERR_LAT   = 0;
    localparam int unsigned ERR_DROP  = 1;
    localparam int unsigned ERR_NOREQ = 2;
    localparam int unsigned ERR_LEN   = 3;
    localparam int unsigned ERR_W     = 4;

    localparam int unsigned WIN_W = 8;
    typedef logic [WIN_W-1:0] win_cnt_t;

endpackage

// File: rtl/wb_dma_hs_ch.sv
// One channel's handshake FSM with its latency and drop windows.
// Emits this cycle's rule violations and a pulse for each completed handshake.
module wb_dma_hs_ch
    import wb_dma_hs_pkg::*;
#(
    parameter int unsigned MAX_LAT  = 4,
    parameter int unsigned MAX_DROP = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             req_rise_i,
    input  logic             ack_i,
    input  logic             cyc_rise_i,
    output logic [ERR_W-1:0] flag_c,
    output logic             done_c
);

    hs_state_t state, state_d;
    win_cnt_t  lat_cnt, lat_d;
    win_cnt_t  drop_cnt, drop_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_d;
            lat_cnt  <= lat_d;
            drop_cnt <= drop_d;
        end
    end

    always_comb begin
        state_d = state;
        lat_d   = lat_cnt;
        drop_d  = drop_cnt;
        flag_c  = '0;
        done_c  = 1'b0;
        case (state)
            IDLE: begin
                flag_c[ERR_NOREQ] = ack_i;
                if (req_rise_i) begin
                    state_d = WAIT_CYC;
                    lat_d   = win_cnt_t'(1);
                end
            end
            WAIT_CYC: begin
                flag_c[ERR_NOREQ] = ack_i;
                // A cyc rise on the last allowed cycle still beats the timeout.
                if (cyc_rise_i) begin
                    state_d = BUSY;
                end else if (!req_i) begin
                    flag_c[ERR_DROP] = 1'b1;
                    state_d          = IDLE;
                end else if (lat_cnt == win_cnt_t'(MAX_LAT)) begin
                    flag_c[ERR_LAT] = 1'b1;
                    state_d         = BUSY;
                end else begin
                    lat_d = lat_cnt + win_cnt_t'(1);
                end
            end
            BUSY: begin
                if (ack_i) begin
                    state_d = ACKED;
                    drop_d  = win_cnt_t'(1);
                end else if (!req_i) begin
                    flag_c[ERR_DROP] = 1'b1;
                    state_d          = IDLE;
                end
            end
            ACKED: begin
                flag_c[ERR_LEN] = ack_i;
                if (!req_i) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end else if (drop_cnt == win_cnt_t'(MAX_DROP)) begin
                    flag_c[ERR_DROP] = 1'b1;
                    state_d          = IDLE;
                end else begin
                    drop_d = drop_cnt + win_cnt_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/wb_dma_hs_checker.sv
// Run-time checker for the DMA req/ack handshake against both Wishbone masters.
// Edge detection, per-channel FSMs, sticky error capture and a saturating handshake count.
module wb_dma_hs_checker
    import wb_dma_hs_pkg::*;
#(
    parameter int unsigned CH_NUM   = 8,
    parameter int unsigned MAX_LAT  = 4,
    parameter int unsigned MAX_DROP = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CH_NUM-1:0] dma_req_i,
    input  logic [CH_NUM-1:0] dma_ack_i,
    input  logic              wb0_cyc_i,
    input  logic              wb1_cyc_i,
    input  logic              err_clr_i,
    output logic              err_o,
    output logic [CH_NUM-1:0] err_ch_o,
    output logic [ERR_W-1:0]  err_type_o,
    output logic [4:0]        first_ch_o,
    output logic [CNT_W-1:0]  hs_cnt_o
);

    localparam int unsigned SUM_W = $clog2(CH_NUM + 1);
    localparam int unsigned ADD_W = ((CNT_W > SUM_W) ? CNT_W : SUM_W) + 1;
    localparam logic [ADD_W-1:0] CNT_MAX = {ADD_W{1'b1}} >> (ADD_W - CNT_W);

    logic [CH_NUM-1:0] req_q;
    logic              cyc0_q, cyc1_q;
    logic [CH_NUM-1:0] req_rise;
    logic              cyc_rise;
    logic [ERR_W-1:0]  ch_flags [CH_NUM];
    logic [CH_NUM-1:0] ch_done;

    assign req_rise = dma_req_i & ~req_q;
    assign cyc_rise = (wb0_cyc_i & ~cyc0_q) | (wb1_cyc_i & ~cyc1_q);

    for (genvar g = 0; g < int'(CH_NUM); g++) begin : g_ch
        wb_dma_hs_ch #(
            .MAX_LAT  (MAX_LAT),
            .MAX_DROP (MAX_DROP)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .req_i      (dma_req_i[g]),
            .req_rise_i (req_rise[g]),
            .ack_i      (dma_ack_i[g]),
            .cyc_rise_i (cyc_rise),
            .flag_c     (ch_flags[g]),
            .done_c     (ch_done[g])
        );
    end

    logic [CH_NUM-1:0] ch_hit;
    logic [ERR_W-1:0]  type_hit;
    logic [SUM_W-1:0]  done_sum;
    logic [4:0]        first_idx;

    // Collapse per-channel flags; the descending scan leaves the lowest index.
    always_comb begin
        ch_hit    = '0;
        type_hit  = '0;
        done_sum  = '0;
        first_idx = '0;
        for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
            ch_hit[i] = |ch_flags[i];
            type_hit  = type_hit | ch_flags[i];
            done_sum  = done_sum + SUM_W'(ch_done[i]);
            if (|ch_flags[i]) begin
                first_idx = 5'(i);
            end
        end
    end

    logic [CH_NUM-1:0] err_ch_d;
    logic [ERR_W-1:0]  err_type_d;
    logic [4:0]        first_d;
    logic [ADD_W-1:0]  hs_sum;
    logic [CNT_W-1:0]  hs_cnt_d;

    // New flags win over a simultaneous clear.
    always_comb begin
        err_ch_d   = (err_clr_i ? '0 : err_ch_o) | ch_hit;
        err_type_d = (err_clr_i ? '0 : err_type_o) | type_hit;
        first_d    = err_clr_i ? 5'd0 : first_ch_o;
        if ((|ch_hit) && (!err_o || err_clr_i)) begin
            first_d = first_idx;
        end
        hs_sum   = ADD_W'(hs_cnt_o) + ADD_W'(done_sum);
        hs_cnt_d = (hs_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(hs_sum);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q      <= '0;
            cyc0_q     <= 1'b0;
            cyc1_q     <= 1'b0;
            err_o      <= 1'b0;
            err_ch_o   <= '0;
            err_type_o <= '0;
            first_ch_o <= '0;
            hs_cnt_o   <= '0;
        end else begin
            req_q      <= dma_req_i;
            cyc0_q     <= wb0_cyc_i;
            cyc1_q     <= wb1_cyc_i;
            err_o      <= |err_ch_d;
            err_ch_o   <= err_ch_d;
            err_type_o <= err_type_d;
            first_ch_o <= first_d;
            hs_cnt_o   <= hs_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_dma_hs_checker.sv
// Directed bench for wb_dma_hs_checker: 8 channels, MAX_LAT=4, MAX_DROP=8, 2-bit counter.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_wb_dma_hs_checker;

    localparam int unsigned CH_NUM   = 8;
    localparam int unsigned MAX_LAT  = 4;
    localparam int unsigned MAX_DROP = 8;
    localparam int unsigned CNT_W    = 2;

    logic              clk_i = 1'b0;
    logic              rst;
    logic [CH_NUM-1:0] req;
    logic [CH_NUM-1:0] ack;
    logic              wb0;
    logic              wb1;
    logic              clr;
    logic              err_o;
    logic [CH_NUM-1:0] err_ch_o;
    logic [3:0]        err_type_o;
    logic [4:0]        first_ch_o;
    logic [CNT_W-1:0]  hs_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    wb_dma_hs_checker #(
        .CH_NUM   (CH_NUM),
        .MAX_LAT  (MAX_LAT),
        .MAX_DROP (MAX_DROP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst),
        .dma_req_i  (req),
        .dma_ack_i  (ack),
        .wb0_cyc_i  (wb0),
        .wb1_cyc_i  (wb1),
        .err_clr_i  (clr),
        .err_o      (err_o),
        .err_ch_o   (err_ch_o),
        .err_type_o (err_type_o),
        .first_ch_o (first_ch_o),
        .hs_cnt_o   (hs_cnt_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; ack = '0; wb0 = 1'b0; wb1 = 1'b0; clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Req rise, wb0 cyc rise, one-cycle ack, req fall on the channels in m.
    task automatic handshake(input logic [CH_NUM-1:0] m);
        req = req | m;
        tick();
        wb0 = 1'b1;
        tick();
        wb0 = 1'b0;
        ack = ack | m;
        tick();
        ack = ack & ~m;
        req = req & ~m;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err_o got %b exp 0", err_o); end
        n_vec++; if (err_ch_o !== 8'h00) begin n_err++; $display("FAIL reset_err_ch got %h exp 00", err_ch_o); end
        n_vec++; if (err_type_o !== 4'b0000) begin n_err++; $display("FAIL reset_err_type got %b exp 0000", err_type_o); end
        n_vec++; if (first_ch_o !== 5'd0) begin n_err++; $display("FAIL reset_first_ch got %0d exp 0", first_ch_o); end
        n_vec++; if (hs_cnt_o !== 2'd0) begin n_err++; $display("FAIL reset_hs_cnt got %0d exp 0", hs_cnt_o); end
    endtask

    task automatic test_legal();
        do_reset();
        req[3] = 1'b1; tick();
        tick();
        wb0 = 1'b1; tick();
        tick(); tick();
        ack[3] = 1'b1; tick();
        n_vec++; if (hs_cnt_o !== 2'd0) begin n_err++; $display("FAIL legal_hs_pre got %0d exp 0", hs_cnt_o); end
        ack[3] = 1'b0; req[3] = 1'b0; tick();
        wb0 = 1'b0;
        n_vec++; if (hs_cnt_o !== 2'd1) begin n_err++; $display("FAIL legal_hs got %0d exp 1", hs_cnt_o); end
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL legal_err_o got %b exp 0", err_o); end
        n_vec++; if (err_type_o !== 4'b0000) begin n_err++; $display("FAIL legal_err_type got %b exp 0000", err_type_o); end
        n_vec++; if (err_ch_o !== 8'h00) begin n_err++; $display("FAIL legal_err_ch got %h exp 00", err_ch_o); end
    endtask

    task automatic test_latency();
        do_reset();
        req[0] = 1'b1; tick();
        tick(); tick(); tick();
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL lat_early got %b exp 0", err_o); end
        tick();
        n_vec++; if (err_type_o !== 4'b0001) begin n_err++; $display("FAIL lat_type got %b exp 0001", err_type_o); end
        n_vec++; if (err_ch_o !== 8'h01) begin n_err++; $display("FAIL lat_ch got %h exp 01", err_ch_o); end
        n_vec++; if (first_ch_o !== 5'd0) begin n_err++; $display("FAIL lat_first got %0d exp 0", first_ch_o); end
        n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL lat_err_o got %b exp 1", err_o); end
        ack[0] = 1'b1; tick();
        ack[0] = 1'b0; req[0] = 1'b0; tick();
        n_vec++; if (hs_cnt_o !== 2'd1) begin n_err++; $display("FAIL lat_hs got %0d exp 1", hs_cnt_o); end
        n_vec++; if (err_type_o !== 4'b0001) begin n_err++; $display("FAIL lat_type_after got %b exp 0001", err_type_o); end
    endtask

    task automatic test_lat_boundary();
        do_reset();
        req[4] = 1'b1; tick();
        tick(); tick(); tick();
        wb1 = 1'b1; tick();
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL latb_err_o got %b exp 0", err_o); end
        ack[4] = 1'b1; tick();
        ack[4] = 1'b0; req[4] = 1'b0; tick();
        wb1 = 1'b0;
        n_vec++; if (hs_cnt_o !== 2'd1) begin n_err++; $display("FAIL latb_hs got %0d exp 1", hs_cnt_o); end
        n_vec++; if (err_ch_o !== 8'h00) begin n_err++; $display("FAIL latb_ch got %h exp 00", err_ch_o); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req[5] = 1'b1; tick();
        req[5] = 1'b0; ack[2] = 1'b1; tick();
        ack[2] = 1'b0;
        n_vec++; if (err_ch_o !== 8'h24) begin n_err++; $display("FAIL sim_ch got %h exp 24", err_ch_o); end
        n_vec++; if (err_type_o !== 4'b0110) begin n_err++; $display("FAIL sim_type got %b exp 0110", err_type_o); end
        n_vec++; if (first_ch_o !== 5'd2) begin n_err++; $display("FAIL sim_first got %0d exp 2", first_ch_o); end
        n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL sim_err_o got %b exp 1", err_o); end
        ack[7] = 1'b1; tick();
        ack[7] = 1'b0;
        n_vec++; if (err_ch_o !== 8'hA4) begin n_err++; $display("FAIL sim_ch2 got %h exp a4", err_ch_o); end
        n_vec++; if (first_ch_o !== 5'd2) begin n_err++; $display("FAIL sim_first_hold got %0d exp 2", first_ch_o); end
    endtask

    task automatic test_long_ack();
        do_reset();
        req[1] = 1'b1; tick();
        wb0 = 1'b1; tick();
        ack[1] = 1'b1; tick();
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL len_first_ack got %b exp 0", err_o); end
        tick();
        n_vec++; if (err_type_o !== 4'b1000) begin n_err++; $display("FAIL len_type got %b exp 1000", err_type_o); end
        n_vec++; if (err_ch_o !== 8'h02) begin n_err++; $display("FAIL len_ch got %h exp 02", err_ch_o); end
        n_vec++; if (first_ch_o !== 5'd1) begin n_err++; $display("FAIL len_first got %0d exp 1", first_ch_o); end
        clr = 1'b1; tick();
        n_vec++; if (err_type_o !== 4'b1000) begin n_err++; $display("FAIL len_clr_race_type got %b exp 1000", err_type_o); end
        n_vec++; if (first_ch_o !== 5'd1) begin n_err++; $display("FAIL len_clr_race_first got %0d exp 1", first_ch_o); end
        clr = 1'b0; ack[1] = 1'b0; tick();
        clr = 1'b1; tick();
        clr = 1'b0;
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL clr_err_o got %b exp 0", err_o); end
        n_vec++; if (err_type_o !== 4'b0000) begin n_err++; $display("FAIL clr_type got %b exp 0000", err_type_o); end
        n_vec++; if (first_ch_o !== 5'd0) begin n_err++; $display("FAIL clr_first got %0d exp 0", first_ch_o); end
        req[1] = 1'b0; tick();
        wb0 = 1'b0;
        n_vec++; if (hs_cnt_o !== 2'd1) begin n_err++; $display("FAIL clr_hs got %0d exp 1", hs_cnt_o); end
    endtask

    task automatic test_drop_window();
        do_reset();
        req[6] = 1'b1; tick();
        wb0 = 1'b1; tick();
        wb0 = 1'b0; ack[6] = 1'b1; tick();
        ack[6] = 1'b0;
        repeat (MAX_DROP - 1) tick();
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL drop_early got %b exp 0", err_o); end
        tick();
        n_vec++; if (err_type_o !== 4'b0010) begin n_err++; $display("FAIL drop_type got %b exp 0010", err_type_o); end
        n_vec++; if (err_ch_o !== 8'h40) begin n_err++; $display("FAIL drop_ch got %h exp 40", err_ch_o); end
        req[6] = 1'b0; tick();
        n_vec++; if (hs_cnt_o !== 2'd0) begin n_err++; $display("FAIL drop_hs got %0d exp 0", hs_cnt_o); end
    endtask

    task automatic test_saturation();
        do_reset();
        handshake(8'h03);
        n_vec++; if (hs_cnt_o !== 2'd2) begin n_err++; $display("FAIL sat_pair got %0d exp 2", hs_cnt_o); end
        handshake(8'h08);
        n_vec++; if (hs_cnt_o !== 2'd3) begin n_err++; $display("FAIL sat_3 got %0d exp 3", hs_cnt_o); end
        handshake(8'h08);
        n_vec++; if (hs_cnt_o !== 2'd3) begin n_err++; $display("FAIL sat_4 got %0d exp 3", hs_cnt_o); end
        handshake(8'h08);
        n_vec++; if (hs_cnt_o !== 2'd3) begin n_err++; $display("FAIL sat_5 got %0d exp 3", hs_cnt_o); end
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL sat_err_o got %b exp 0", err_o); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        handshake(8'h04);
        ack[7] = 1'b1; tick();
        ack[7] = 1'b0;
        n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL rstm_pre_err got %b exp 1", err_o); end
        req[2] = 1'b1; tick();
        wb0 = 1'b1; tick();
        rst = 1'b1; tick();
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL rstm_err_o got %b exp 0", err_o); end
        n_vec++; if (err_ch_o !== 8'h00) begin n_err++; $display("FAIL rstm_ch got %h exp 00", err_ch_o); end
        n_vec++; if (err_type_o !== 4'b0000) begin n_err++; $display("FAIL rstm_type got %b exp 0000", err_type_o); end
        n_vec++; if (first_ch_o !== 5'd0) begin n_err++; $display("FAIL rstm_first got %0d exp 0", first_ch_o); end
        n_vec++; if (hs_cnt_o !== 2'd0) begin n_err++; $display("FAIL rstm_hs got %0d exp 0", hs_cnt_o); end
        rst = 1'b0; tick();
        tick(); tick(); tick();
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL rstm_lat_early got %b exp 0", err_o); end
        tick();
        n_vec++; if (err_type_o !== 4'b0001) begin n_err++; $display("FAIL rstm_lat_type got %b exp 0001", err_type_o); end
        n_vec++; if (err_ch_o !== 8'h04) begin n_err++; $display("FAIL rstm_lat_ch got %h exp 04", err_ch_o); end
        n_vec++; if (first_ch_o !== 5'd2) begin n_err++; $display("FAIL rstm_lat_first got %0d exp 2", first_ch_o); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_legal();
        test_latency();
        test_lat_boundary();
        test_simultaneous();
        test_long_ack();
        test_drop_window();
        test_saturation();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
